// File: rtl/fifo_write_arbiter_if.sv
// Write-port bundle between the requesters, the arbiter and the FIFO
// write-pointer block.
interface fifo_write_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ID_WIDTH   = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          fifo_full;
    logic                          write_enable;
    logic [DATA_WIDTH-1:0]         write_data;
    logic                          grant_valid;
    logic [ID_WIDTH-1:0]           grant_id;

    modport slave (
        input  req_valid,
        input  req_last,
        input  req_data,
        input  fifo_full,
        output req_ready,
        output write_enable,
        output write_data,
        output grant_valid,
        output grant_id
    );

    modport master (
        output req_valid,
        output req_last,
        output req_data,
        output fifo_full,
        input  req_ready,
        input  write_enable,
        input  write_data,
        input  grant_valid,
        input  grant_id
    );
endinterface

// File: rtl/fifo_write_arbiter.sv
// Burst-oriented round-robin arbiter sharing the async FIFO write port
// among NUM_REQ requesters in the write clock domain.
module fifo_write_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4,
    parameter int ID_WIDTH   = $clog2(NUM_REQ),
    parameter int CNT_WIDTH  = $clog2(MAX_BURST) + 1
) (
    input  logic write_clk,
    input  logic write_reset,
    fifo_write_arbiter_if.slave bus
);
    typedef enum logic {ARB, BURST} state_t;

    state_t                state;
    logic [ID_WIDTH-1:0]   rr_last;
    logic [ID_WIDTH-1:0]   grant_id;
    logic                  grant_valid;
    logic [CNT_WIDTH-1:0]  burst_cnt;

    logic [ID_WIDTH-1:0]   winner;
    logic                  any_valid;
    int                    scan_idx;
    logic                  in_burst;
    logic                  cur_valid;
    logic                  cur_last;
    logic                  xfer;
    logic                  final_beat;

    // Walk downward so the nearest index after rr_last wins; rr_last itself
    // is considered last.
    always_comb begin
        winner    = '0;
        any_valid = 1'b0;
        scan_idx  = 0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            scan_idx = (int'(rr_last) + i) % NUM_REQ;
            if (bus.req_valid[scan_idx]) begin
                winner    = ID_WIDTH'(scan_idx);
                any_valid = 1'b1;
            end
        end
    end

    assign in_burst   = (state == BURST);
    assign cur_valid  = bus.req_valid[grant_id];
    assign cur_last   = bus.req_last[grant_id];
    assign xfer       = in_burst & cur_valid & ~bus.fifo_full;
    assign final_beat = cur_last |
                        (burst_cnt == CNT_WIDTH'(MAX_BURST - 1));

    always_comb begin
        bus.req_ready = '0;
        if (in_burst && !bus.fifo_full) begin
            bus.req_ready[grant_id] = 1'b1;
        end
    end

    assign bus.write_enable = xfer;
    assign bus.write_data   = xfer ?
        bus.req_data[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH] :
        '0;
    assign bus.grant_valid  = grant_valid;
    assign bus.grant_id     = grant_id;

    always_ff @(posedge write_clk or posedge write_reset) begin
        if (write_reset) begin
            state       <= ARB;
            grant_valid <= 1'b0;
            grant_id    <= '0;
            burst_cnt   <= '0;
            rr_last     <= ID_WIDTH'(NUM_REQ - 1);
        end else begin
            unique case (state)
                ARB: begin
                    if (any_valid) begin
                        grant_id    <= winner;
                        grant_valid <= 1'b1;
                        burst_cnt   <= '0;
                        rr_last     <= winner;
                        state       <= BURST;
                    end
                end
                BURST: begin
                    if (!cur_valid) begin
                        state       <= ARB;
                        grant_valid <= 1'b0;
                        grant_id    <= '0;
                    end else if (xfer) begin
                        burst_cnt <= burst_cnt + 1'b1;
                        if (final_beat) begin
                            state       <= ARB;
                            grant_valid <= 1'b0;
                            grant_id    <= '0;
                        end
                    end
                end
                default: state <= ARB;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter: reset, rotation, early last,
// backpressure, valid drop and reset mid-burst.
module tb_fifo_write_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fifo_write_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(8)) bus ();

    fifo_write_arbiter #(
        .NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(4)
    ) dut (
        .write_clk(clk),
        .write_reset(rst),
        .bus(bus.slave)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] wr_q[$];

    always @(negedge clk) begin
        if (bus.write_enable) wr_q.push_back(bus.write_data);
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_word(input int i, input logic [7:0] v);
        bus.req_data[i*8 +: 8] = v;
    endtask

    task automatic do_reset(input logic [3:0] v);
        cyc();
        rst = 1'b1;
        bus.req_valid = v;
        bus.req_last  = '0;
        bus.fifo_full = 1'b0;
        @(negedge clk);
        check("rst_gv", 32'(bus.grant_valid), 0);
        check("rst_we", 32'(bus.write_enable), 0);
        check("rst_rdy", 32'(bus.req_ready), 0);
        check("rst_gid", 32'(bus.grant_id), 0);
        check("rst_wd", 32'(bus.write_data), 0);
        cyc();
        rst = 1'b0;
        wr_q.delete();
        @(negedge clk);
        check("arb_gv", 32'(bus.grant_valid), 0);
        check("arb_we", 32'(bus.write_enable), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got running expected done");
        $fatal(1, "timeout");
    end

    initial begin
        bus.req_valid = '0;
        bus.req_last  = '0;
        bus.req_data  = '0;
        bus.fifo_full = 1'b0;
        repeat (2) @(posedge clk);

        // Round robin: every requester always valid, no last.
        for (int i = 0; i < 4; i++) set_word(i, 8'(8'h10 * (i + 1)));
        do_reset(4'b1111);
        for (int c = 0; c < 25; c++) begin
            int ph, g;
            cyc();
            @(negedge clk);
            ph = c % 5;
            g  = (c / 5) % 4;
            if (ph < 4) begin
                check("rr_gv", 32'(bus.grant_valid), 1);
                check("rr_gid", 32'(bus.grant_id), 32'(g));
                check("rr_we", 32'(bus.write_enable), 1);
                check("rr_wd", 32'(bus.write_data), 32'(8'h10 * (g + 1)));
                check("rr_rdy", 32'(bus.req_ready), 32'(1 << g));
            end else begin
                check("rr_bub_gv", 32'(bus.grant_valid), 0);
                check("rr_bub_we", 32'(bus.write_enable), 0);
            end
        end
        #1;
        check("rr_count", 32'(wr_q.size()), 20);
        for (int k = 0; k < wr_q.size(); k++)
            check("rr_order", 32'(wr_q[k]), 32'(8'h10 * ((k / 4) % 4 + 1)));

        // Early last from requester 2.
        set_word(2, 8'hA1);
        do_reset(4'b0100);
        cyc();
        @(negedge clk);
        check("el_gid", 32'(bus.grant_id), 2);
        check("el_we1", 32'(bus.write_enable), 1);
        check("el_wd1", 32'(bus.write_data), 32'h A1);
        check("el_rdy", 32'(bus.req_ready), 32'b0100);
        cyc();
        set_word(2, 8'hA2);
        bus.req_last = 4'b0100;
        @(negedge clk);
        check("el_we2", 32'(bus.write_enable), 1);
        check("el_wd2", 32'(bus.write_data), 32'h A2);
        cyc();
        bus.req_valid = 4'b1011;
        bus.req_last  = '0;
        @(negedge clk);
        check("el_rel_gv", 32'(bus.grant_valid), 0);
        check("el_rel_we", 32'(bus.write_enable), 0);
        #1;
        check("el_count", 32'(wr_q.size()), 2);
        if (wr_q.size() == 2) begin
            check("el_w0", 32'(wr_q[0]), 32'h A1);
            check("el_w1", 32'(wr_q[1]), 32'h A2);
        end
        cyc();
        @(negedge clk);
        check("el_next_gid", 32'(bus.grant_id), 3);
        check("el_next_gv", 32'(bus.grant_valid), 1);

        // Backpressure during requester 1 burst.
        set_word(1, 8'hB1);
        do_reset(4'b0010);
        cyc();
        @(negedge clk);
        check("bp_we1", 32'(bus.write_enable), 1);
        check("bp_wd1", 32'(bus.write_data), 32'h B1);
        check("bp_gid", 32'(bus.grant_id), 1);
        for (int k = 0; k < 3; k++) begin
            cyc();
            bus.fifo_full = 1'b1;
            set_word(1, 8'hB2);
            @(negedge clk);
            check("bp_full_we", 32'(bus.write_enable), 0);
            check("bp_full_rdy", 32'(bus.req_ready), 0);
            check("bp_full_gid", 32'(bus.grant_id), 1);
            check("bp_full_gv", 32'(bus.grant_valid), 1);
        end
        for (int k = 2; k <= 4; k++) begin
            cyc();
            bus.fifo_full = 1'b0;
            set_word(1, 8'(8'hB0 + k));
            @(negedge clk);
            check("bp_we", 32'(bus.write_enable), 1);
            check("bp_wd", 32'(bus.write_data), 32'(8'hB0 + k));
        end
        cyc();
        bus.req_valid = '0;
        @(negedge clk);
        check("bp_end_gv", 32'(bus.grant_valid), 0);
        #1;
        check("bp_count", 32'(wr_q.size()), 4);
        for (int k = 0; k < wr_q.size(); k++)
            check("bp_word", 32'(wr_q[k]), 32'(8'hB1 + k));

        // Requester 3 drops valid after one beat.
        set_word(3, 8'hC1);
        set_word(0, 8'hD0);
        do_reset(4'b1000);
        cyc();
        @(negedge clk);
        check("vd_gid", 32'(bus.grant_id), 3);
        check("vd_wd", 32'(bus.write_data), 32'h C1);
        cyc();
        bus.req_valid = 4'b0001;
        @(negedge clk);
        check("vd_hold_gv", 32'(bus.grant_valid), 1);
        check("vd_hold_we", 32'(bus.write_enable), 0);
        cyc();
        @(negedge clk);
        check("vd_rel_gv", 32'(bus.grant_valid), 0);
        #1;
        check("vd_count", 32'(wr_q.size()), 1);
        cyc();
        @(negedge clk);
        check("vd_next_gid", 32'(bus.grant_id), 0);
        check("vd_next_wd", 32'(bus.write_data), 32'h D0);

        // Reset asserted during beat 2 of requester 1.
        set_word(1, 8'hE1);
        set_word(0, 8'hF0);
        do_reset(4'b0010);
        cyc();
        @(negedge clk);
        check("mr_gid", 32'(bus.grant_id), 1);
        check("mr_wd1", 32'(bus.write_data), 32'h E1);
        cyc();
        set_word(1, 8'hE2);
        @(negedge clk);
        check("mr_we2", 32'(bus.write_enable), 1);
        #1;
        rst = 1'b1;
        #1;
        check("mr_async_we", 32'(bus.write_enable), 0);
        check("mr_async_gv", 32'(bus.grant_valid), 0);
        check("mr_async_rdy", 32'(bus.req_ready), 0);
        cyc();
        bus.req_valid = 4'b0011;
        cyc();
        rst = 1'b0;
        @(negedge clk);
        check("mr_arb_gv", 32'(bus.grant_valid), 0);
        cyc();
        @(negedge clk);
        check("mr_next_gid", 32'(bus.grant_id), 0);
        check("mr_next_wd", 32'(bus.write_data), 32'h F0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end
endmodule
